// File: rtl/vector_sweep_ctrl_pkg.sv
// Shared types and constants for the vector sweep controller.
// The sequencer states and the signature (MISR) parameters live here.
package sweep_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      APPLY = 3'd1,
      WAIT  = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int             SIG_W    = 16;
   localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
   localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/vector_sweep_ctrl_if.sv
// Record channel from the sweep controller to the downstream logger.
// Handshake: the master raises rec_valid with rec_vec/rec_resp and keeps all
// three stable until it samples rec_valid && rec_ready on a rising edge; a
// record transfers on exactly that edge. rec_ready may change freely and
// does not depend on rec_valid.
interface vector_sweep_ctrl_if #(
   parameter int N_IN  = 3,
   parameter int OUT_W = 1
);
   logic             rec_valid;
   logic             rec_ready;
   logic [N_IN-1:0]  rec_vec;
   logic [OUT_W-1:0] rec_resp;

   modport master (output rec_valid, output rec_vec, output rec_resp, input rec_ready);
   modport slave  (input rec_valid, input rec_vec, input rec_resp, output rec_ready);
endinterface

// File: rtl/vector_sweep_ctrl_misr.sv
// 16-bit multiple-input signature register over sweep records.
// clear seeds the register, en folds one zero-extended record into it.
module sweep_misr
   import sweep_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [SIG_W-1:0]  sig
);

   // A record wider than the signature cannot be folded in without loss.
   if (DATA_W > SIG_W) begin : g_width_check
      $error("sweep_misr: record width DATA_W exceeds signature width");
   end

   // Signature register: reset to 0, seed on clear, shift/feedback/fold on en.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= '0;
      end else if (clear) begin
         sig <= SIG_SEED;
      end else if (en) begin
         sig <= {sig[SIG_W-2:0], 1'b0}
              ^ (sig[SIG_W-1] ? SIG_POLY : '0)
              ^ SIG_W'(data);
      end
   end

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweeper: drives every vector 0 .. 2^N_IN-1 to a small DUT,
// waits SETTLE extra cycles, samples the response and streams one
// {vector, response} record per vector over the rec channel.
// Optional feature macro: SWEEP_SIG_EN (response signature on sig_out).
module vector_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int OUT_W  = 1,
   parameter int SETTLE = 1
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [N_IN-1:0]  vec_out,
   input  logic [OUT_W-1:0] dut_out,
   vector_sweep_ctrl_if.master rec,
   output logic [SIG_W-1:0] sig_out,
   output state_t           dbg_state
);

   // Settle counter only ever holds SETTLE-1 down to 0.
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

   state_t           state;
   logic [N_IN-1:0]  index;
   logic [CNT_W-1:0] cnt;
   logic             rec_valid_q;
   logic [N_IN-1:0]  rec_vec_q;
   logic [OUT_W-1:0] rec_resp_q;
   logic             enter_emit;

   assign rec.rec_valid = rec_valid_q;
   assign rec.rec_vec   = rec_vec_q;
   assign rec.rec_resp  = rec_resp_q;
   assign dbg_state     = state;

   // The response is sampled on the edge that leaves APPLY (no settle) or
   // that ends the settle countdown.
   always_comb begin
      enter_emit = 1'b0;
      if (state == APPLY && SETTLE == 0) enter_emit = 1'b1;
      if (state == WAIT && cnt == '0)    enter_emit = 1'b1;
   end

   // Sweep sequencer with all outputs registered.
   always_ff @(posedge CK) begin
      if (reset) begin
         state       <= IDLE;
         index       <= '0;
         cnt         <= '0;
         vec_out     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rec_valid_q <= 1'b0;
         rec_vec_q   <= '0;
         rec_resp_q  <= '0;
      end else begin
         done <= 1'b0;
         if (enter_emit) begin
            rec_vec_q   <= vec_out;
            rec_resp_q  <= dut_out;
            rec_valid_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= APPLY;
                  vec_out <= '0;
                  index   <= '0;
                  busy    <= 1'b1;
               end
            end
            APPLY: begin
               if (SETTLE == 0) begin
                  state <= EMIT;
               end else begin
                  state <= WAIT;
                  cnt   <= CNT_W'(SETTLE - 1);
               end
            end
            WAIT: begin
               if (cnt == '0) state <= EMIT;
               else           cnt   <= cnt - 1'b1;
            end
            EMIT: begin
               if (rec_valid_q && rec.rec_ready) begin
                  rec_valid_q <= 1'b0;
                  if (index == LAST_VEC) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     index   <= index + 1'b1;
                     vec_out <= index + 1'b1;
                     state   <= APPLY;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SWEEP_SIG_EN
   logic rec_fire;
   logic sig_clear;

   // Fold every accepted record; reseed when a sweep is accepted.
   assign rec_fire  = (state == EMIT) && rec_valid_q && rec.rec_ready;
   assign sig_clear = (state == IDLE) && start;

   sweep_misr #(.DATA_W(N_IN + OUT_W)) u_misr (
      .clk   (CK),
      .rst   (reset),
      .clear (sig_clear),
      .en    (rec_fire),
      .data  ({rec_vec_q, rec_resp_q}),
      .sig   (sig_out)
   );
`else
   assign sig_out = '0;
`endif

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Bench for vector_sweep_ctrl: main instance (SETTLE=1, combinational parity
// DUT) plus SETTLE=0 and SETTLE=3 instances driven by a registered parity DUT.
module tb_vector_sweep_ctrl;
   import sweep_pkg::*;

   typedef logic [3:0] rec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic start = 1'b0, start0 = 1'b0, start3 = 1'b0;
   logic rec_ready = 1'b1;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // ---------------- main instance ----------------
   logic        busy, done, dut_out;
   logic [2:0]  vec_out;
   logic [15:0] sig_out;
   state_t      st_main;
   vector_sweep_ctrl_if #(.N_IN(3), .OUT_W(1)) rec_if ();
   assign dut_out          = ^vec_out;
   assign rec_if.rec_ready = rec_ready;

   vector_sweep_ctrl #(.N_IN(3), .OUT_W(1), .SETTLE(1)) u_dut (
      .CK(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .vec_out(vec_out), .dut_out(dut_out), .rec(rec_if),
      .sig_out(sig_out), .dbg_state(st_main)
   );

   // ---------------- SETTLE=0 / SETTLE=3 instances ----------------
   logic        busy0, done0, busy3, done3;
   logic        par0, par3;
   logic [2:0]  vec0, vec3;
   logic [15:0] sig0, sig3;
   state_t      st0, st3;
   vector_sweep_ctrl_if #(.N_IN(3), .OUT_W(1)) rec0_if ();
   vector_sweep_ctrl_if #(.N_IN(3), .OUT_W(1)) rec3_if ();
   assign rec0_if.rec_ready = 1'b1;
   assign rec3_if.rec_ready = 1'b1;

   // Registered parity DUT, updated half a cycle after the vector changes.
   always @(negedge clk) begin
      par0 <= ^vec0;
      par3 <= ^vec3;
   end

   vector_sweep_ctrl #(.N_IN(3), .OUT_W(1), .SETTLE(0)) u_s0 (
      .CK(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
      .vec_out(vec0), .dut_out(par0), .rec(rec0_if),
      .sig_out(sig0), .dbg_state(st0)
   );
   vector_sweep_ctrl #(.N_IN(3), .OUT_W(1), .SETTLE(3)) u_s3 (
      .CK(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
      .vec_out(vec3), .dut_out(par3), .rec(rec3_if),
      .sig_out(sig3), .dbg_state(st3)
   );

   // ---------------- checking helpers / model ----------------
   task automatic chk(input bit ok, input string name, input int act, input int req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // Record k of a sweep: vector k and its odd parity.
   function automatic rec_t model_rec(input int k);
      logic [2:0] v;
      v = k[2:0];
      return {v, ^v};
   endfunction

   // Signature of one full sweep, folding records in order from the seed.
   function automatic logic [15:0] misr_model();
      logic [15:0] s;
      s = 16'hFFFF;
      for (int k = 0; k < 8; k++)
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, model_rec(k)};
      return s;
   endfunction

   // ---------------- scoreboard for the main instance ----------------
   rec_t exp_q[$];
   int   rec_count  = 0;
   int   done_count = 0;
   int   accept_cyc = 0;
   int   exp_delta  = 24;
   bit   prev_stall = 0;
   bit   after_done = 0;
   logic [2:0] prev_vec;
   logic       prev_resp;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 0;
         after_done = 0;
      end else begin
         if (rec_if.rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
               chk(0, "rec_unexpected", {rec_if.rec_vec, rec_if.rec_resp}, 0);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               chk({rec_if.rec_vec, rec_if.rec_resp} == e, "rec",
                   {rec_if.rec_vec, rec_if.rec_resp}, e);
            end
            chk(vec_out == rec_if.rec_vec, "vec_out_matches_rec", vec_out, rec_if.rec_vec);
            rec_count++;
         end
         if (prev_stall) begin
            chk(rec_if.rec_valid == 1'b1, "stall_valid", rec_if.rec_valid, 1);
            chk(rec_if.rec_vec == prev_vec, "stall_vec", rec_if.rec_vec, prev_vec);
            chk(rec_if.rec_resp == prev_resp, "stall_resp", rec_if.rec_resp, prev_resp);
            chk(vec_out == prev_vec, "stall_vec_out", vec_out, prev_vec);
         end
         prev_stall = rec_if.rec_valid && !rec_ready;
         prev_vec   = rec_if.rec_vec;
         prev_resp  = rec_if.rec_resp;
         if (rec_if.rec_valid) chk(busy == 1'b1, "busy_while_valid", busy, 1);
         if (done) begin
            done_count++;
            chk(cyc - accept_cyc == exp_delta, "done_time", cyc - accept_cyc, exp_delta);
            chk(rec_count == 8, "rec_count", rec_count, 8);
            chk(exp_q.size() == 0, "exp_q_empty", exp_q.size(), 0);
            after_done = 1;
         end else if (after_done) begin
            chk(busy == 1'b0, "busy_after_done", busy, 0);
            after_done = 0;
         end
`ifndef SWEEP_SIG_EN
         chk(sig_out == 16'h0, "sig_zero", sig_out, 0);
         chk(sig0 == 16'h0 && sig3 == 16'h0, "sig_zero_aux", sig0 | sig3, 0);
`endif
      end
   end

   // ---------------- monitors for SETTLE=0 / SETTLE=3 ----------------
   int n0 = 0, n3 = 0, dn0 = 0, dn3 = 0, acc5 = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (rec0_if.rec_valid) begin
            chk({rec0_if.rec_vec, rec0_if.rec_resp} == model_rec(n0), "s0_rec",
                {rec0_if.rec_vec, rec0_if.rec_resp}, model_rec(n0));
            n0++;
         end
         if (done0) begin
            chk(cyc - acc5 == 16, "s0_done_time", cyc - acc5, 16);
            chk(n0 == 8, "s0_rec_count", n0, 8);
            dn0++;
         end
         if (rec3_if.rec_valid) begin
            chk({rec3_if.rec_vec, rec3_if.rec_resp} == model_rec(n3), "s3_rec",
                {rec3_if.rec_vec, rec3_if.rec_resp}, model_rec(n3));
            n3++;
         end
         if (done3) begin
            chk(cyc - acc5 == 40, "s3_done_time", cyc - acc5, 40);
            chk(n3 == 8, "s3_rec_count", n3, 8);
            dn3++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_sweep(input int delta);
      @(negedge clk);
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back(model_rec(k));
      rec_count = 0;
      exp_delta = delta;
      start     = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      start      = 1'b0;
      chk(busy == 1'b1, "busy_after_accept", busy, 1);
`ifdef SWEEP_SIG_EN
      chk(sig_out == 16'hFFFF, "sig_seed", sig_out, 16'hFFFF);
`endif
   endtask

   task automatic wait_rec(input logic [2:0] v);
      bit found;
      int n;
      found = 0;
      n = 0;
      while (!found && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (rec_if.rec_valid && rec_if.rec_vec == v) found = 1;
      end
      if (!found) chk(0, "wait_rec_timeout", n, 100);
   endtask

   task automatic wait_done();
      int d0;
      int n;
      d0 = done_count;
      n  = 0;
      while (done_count == d0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (done_count == d0) chk(0, "done_timeout", n, 300);
      repeat (3) @(posedge clk);
      #1;
`ifdef SWEEP_SIG_EN
      chk(sig_out == misr_model(), "sig_final", sig_out, misr_model());
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk(vec_out == 3'b000, "rst_vec_out", vec_out, 0);
      chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", {busy, done}, 0);
      chk(rec_if.rec_valid == 1'b0, "rst_rec_valid", rec_if.rec_valid, 0);
      chk({rec_if.rec_vec, rec_if.rec_resp} == 4'h0, "rst_rec_fields",
          {rec_if.rec_vec, rec_if.rec_resp}, 0);
      chk(sig_out == 16'h0000, "rst_sig", sig_out, 0);
      reset = 1'b0;
      @(posedge clk);

      // 1: plain sweep, parity DUT, no back-pressure.
      start_sweep(24);
      wait_rec(3'b000);
      chk(rec_if.rec_resp == 1'b0, "first_rec_resp", rec_if.rec_resp, 0);
      wait_done();
      chk(done_count == 1, "done_count_1", done_count, 1);

      // 2: five cycles of back-pressure on record 011.
      start_sweep(29);
      wait_rec(3'b011);
      rec_ready = 1'b0;
      chk(rec_if.rec_resp == 1'b0, "stall_rec_resp_lit", rec_if.rec_resp, 0);
      repeat (5) @(posedge clk);
      #1;
      rec_ready = 1'b1;
      wait_done();
      chk(done_count == 2, "done_count_2", done_count, 2);

      // 3: reset mid-sweep, then reset+start together, then a fresh sweep.
      start_sweep(24);
      begin
         int n;
         n = 0;
         while (vec_out != 3'b100 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk(vec_out == 3'b100, "reach_vec_100", vec_out, 4);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk(vec_out == 3'b000, "midrst_vec_out", vec_out, 0);
      chk(busy == 1'b0, "midrst_busy", busy, 0);
      chk(rec_if.rec_valid == 1'b0, "midrst_rec_valid", rec_if.rec_valid, 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk(busy == 1'b0, "rst_wins_busy", busy, 0);
      chk(st_main == IDLE, "rst_wins_state", st_main, IDLE);
      start = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      @(posedge clk);
      start_sweep(24);
      wait_done();
      chk(done_count == 3, "done_count_3", done_count, 3);

      // 4: start re-pulsed mid-sweep is ignored.
      start_sweep(24);
      wait_rec(3'b010);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_rec(3'b110);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      repeat (10) @(posedge clk);
      #1;
      chk(done_count == 4, "done_count_4", done_count, 4);
      chk(busy == 1'b0, "idle_busy", busy, 0);
      chk(st_main == IDLE, "idle_state", st_main, IDLE);

      // 5: SETTLE=0 and SETTLE=3 with a registered DUT.
      @(negedge clk);
      n0 = 0;
      n3 = 0;
      start0 = 1'b1;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      acc5   = cyc;
      start0 = 1'b0;
      start3 = 1'b0;
      begin
         int n;
         n = 0;
         while ((dn0 == 0 || dn3 == 0) && n < 100) begin
            @(posedge clk);
            n++;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk(dn0 == 1, "s0_done_count", dn0, 1);
      chk(dn3 == 1, "s3_done_count", dn3, 1);
      chk(busy0 == 1'b0 && busy3 == 1'b0, "aux_busy_low", {busy0, busy3}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog: the sequence above needs well under a thousand cycles.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vector_sweep_ctrl.md
Name: vector_sweep_ctrl

Overview:
Self-contained sequencer that sweeps every input combination through a small sequential DUT and streams out one response record per vector. It drives the DUT input bus, waits a programmable settle time, samples the DUT output, and hands {vector, response} to a downstream logger over a valid/ready handshake. It replaces hand-written per-vector stimulus blocks in the benchmark-testing flow.

Parameters:
N_IN, 3, DUT input width; sweep covers 0 .. 2^N_IN-1 in ascending order.
OUT_W, 1, DUT output width.
SETTLE, 1, extra wait cycles between driving a vector and sampling; SETTLE >= 0.

Ports:
CK  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE.
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  one-cycle pulse when the sweep completes.
vec_out  output  N_IN  registered vector driven to the DUT.
dut_out  input  OUT_W  DUT response.
rec_valid  output  1  record available.
rec_ready  input  1  downstream accepts the record.
rec_vec  output  N_IN  vector belonging to the record.
rec_resp  output  OUT_W  sampled DUT response.
sig_out  output  16  response signature (see Optional Feature).

Behaviour:
- Reset (any state, including mid-sweep): next state IDLE; vec_out=0, index=0, busy=0, done=0, rec_valid=0, rec_vec=0, rec_resp=0, sig_out=0.
- States: IDLE, APPLY, WAIT, EMIT, DONE.
- IDLE: start=1 -> APPLY. vec_out<=0, index<=0, busy<=1 on the same edge.
- APPLY: 1 cycle, vec_out already holds index. If SETTLE=0 -> EMIT, else -> WAIT with counter<=SETTLE-1.
- WAIT: count down; at 0 -> EMIT.
- Transition into EMIT: rec_resp<=dut_out, rec_vec<=vec_out, rec_valid<=1. dut_out is sampled SETTLE+1 edges after vec_out changed.
- EMIT: hold rec_valid and all rec fields stable until rec_valid&&rec_ready. Then:
  - If index != 2^N_IN-1: index+1, vec_out updated, -> APPLY, rec_valid<=0.
  - Else -> DONE, rec_valid<=0.
- Back-pressure is unbounded; vec_out holds during the stall.
- DONE: 1 cycle, done=1, busy=0 on exit -> IDLE.
- With rec_ready tied high, each record takes SETTLE+2 cycles, so done is asserted 2^N_IN*(SETTLE+2) cycles after the start-accept edge.
- start while not IDLE is ignored (no restart, no queueing).
- index is N_IN bits. Last-vector detection compares to all-ones; no wrap to 0 is ever emitted.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: SWEEP_SIG_EN.
- Defined:
  - sig_out is a 16-bit MISR, polynomial 0x1021, seeded to 0xFFFF on start acceptance.
  - Updated on every record handshake: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended {rec_vec, rec_resp}.
  - Holds its value after DONE until the next start or reset.
  - Elaboration error if N_IN+OUT_W > 16.
- Undefined: sig_out tied to 0 and no MISR logic is synthesised.

Decomposition:
- sweep_pkg holds: state enum (IDLE, APPLY, WAIT, EMIT, DONE), SIG_W=16, SIG_POLY=16'h1021, SIG_SEED=16'hFFFF.
- One sub-module, sweep_misr (clear/seed, enable, data in, sig out), instantiated only under SWEEP_SIG_EN.

Test Plan:
1. Defaults (N_IN=3, OUT_W=1, SETTLE=1), parity DUT, rec_ready=1, start pulse -> 8 records in order 000/0, 001/1, 010/1, 011/0, 100/1, 101/0, 110/0, 111/1; done pulses once, exactly 24 cycles after the start-accept edge; busy low afterwards.
2. rec_ready low for 5 cycles while record 011 is valid -> rec_valid stays 1, rec_vec=011, rec_resp=0 stable, vec_out=011 held; sweep then resumes with 100; total 29 cycles.
3. reset asserted while vec_out=100 -> next cycle vec_out=000, busy=0, rec_valid=0; a new start yields a complete 8-record sweep starting at 000.
4. start re-pulsed at records 2 and 6 -> ignored; exactly 8 records and one done pulse.
5. SETTLE=0 and SETTLE=3 with a 1-cycle registered DUT (dut_out = registered parity) -> correct responses, and done at 16 and 40 cycles respectively.
6. SWEEP_SIG_EN defined -> sig_out=0xFFFF after start and equals the bench reference-model MISR value after done; a second identical sweep reproduces the same value. Undefined -> sig_out=0 throughout.
